// File: rtl/mam_arb_pkg.sv
// Shared types and constants for the MAM request arbiter.
package mam_arb_pkg;

    localparam int unsigned MAM_BEATS_W = 14;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWrite,
        StRead
    } mam_arb_state_t;

endpackage

// File: rtl/mam_arb_select.sv
// One-hot winner selection for the MAM arbiter.
// MAM_ARB_RR_EN: round-robin from last winner + 1; otherwise lowest index wins.
module mam_arb_select
    import mam_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
`ifdef MAM_ARB_RR_EN
    input  logic [$clog2(N_REQ)-1:0] last_i,
`endif
    output logic [N_REQ-1:0]         win_o
);

    always_comb begin
        logic found;
        found = 1'b0;
        win_o = '0;
`ifdef MAM_ARB_RR_EN
        // Scan offsets in order; at each offset exactly one index is the candidate.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && req_i[i] && (i == (32'(last_i) + k + 32'd1) % N_REQ)) begin
                    win_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
`else
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req_i[k]) begin
                win_o[k] = 1'b1;
                found    = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/mam_req_arbiter.sv
// Shares one MAM access port between N_REQ requesters, locking the grant for a full transaction.
// MAM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module mam_req_arbiter
    import mam_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                           CLK_I,
    input  logic                           RST_NI,

    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_rw,
    input  logic [N_REQ-1:0]               req_burst,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [N_REQ*MAM_BEATS_W-1:0]   req_beats,
    output logic [N_REQ-1:0]               req_ready,

    input  logic [N_REQ-1:0]               write_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]    write_data,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]  write_strb,
    output logic [N_REQ-1:0]               write_ready,

    output logic [N_REQ-1:0]               read_valid,
    output logic [DATA_WIDTH-1:0]          read_data,
    input  logic [N_REQ-1:0]               read_ready,

    output logic                           m_req_valid,
    input  logic                           m_req_ready,
    output logic                           m_req_rw,
    output logic                           m_req_burst,
    output logic [ADDR_WIDTH-1:0]          m_req_addr,
    output logic [MAM_BEATS_W-1:0]         m_req_beats,

    output logic                           m_write_valid,
    output logic [DATA_WIDTH-1:0]          m_write_data,
    output logic [DATA_WIDTH/8-1:0]        m_write_strb,
    input  logic                           m_write_ready,

    input  logic                           m_read_valid,
    input  logic [DATA_WIDTH-1:0]          m_read_data,
    output logic                           m_read_ready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [MAM_BEATS_W-1:0] ONE_BEAT = MAM_BEATS_W'(1);

    mam_arb_state_t         state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [N_REQ-1:0]       win;
    logic [MAM_BEATS_W-1:0] beats_q, beats_d;

    logic                   sel_req_valid, sel_rw, sel_burst;
    logic                   sel_write_valid, sel_read_ready;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [MAM_BEATS_W-1:0] sel_beats, sel_eff_beats;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [STRB_W-1:0]      sel_wstrb;

`ifdef MAM_ARB_RR_EN
    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (win[i]) begin
                    last_d = PTR_W'(i);
                end
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            last_q <= PTR_W'(N_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    mam_arb_select #(
        .N_REQ (N_REQ)
    ) u_select (
        .req_i  (req_valid),
`ifdef MAM_ARB_RR_EN
        .last_i (last_q),
`endif
        .win_o  (win)
    );

    // Granted-slice mux; grant_q is one-hot (or zero in IDLE).
    always_comb begin
        sel_req_valid   = 1'b0;
        sel_rw          = 1'b0;
        sel_burst       = 1'b0;
        sel_write_valid = 1'b0;
        sel_read_ready  = 1'b0;
        sel_addr        = '0;
        sel_beats       = '0;
        sel_wdata       = '0;
        sel_wstrb       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                sel_req_valid   = req_valid[i];
                sel_rw          = req_rw[i];
                sel_burst       = req_burst[i];
                sel_write_valid = write_valid[i];
                sel_read_ready  = read_ready[i];
                sel_addr        = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_beats       = req_beats[i*MAM_BEATS_W +: MAM_BEATS_W];
                sel_wdata       = write_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb       = write_strb[i*STRB_W +: STRB_W];
            end
        end
    end

    // A zero-length burst still moves one beat.
    assign sel_eff_beats = (sel_burst && (sel_beats != '0)) ? sel_beats : ONE_BEAT;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        beats_d       = beats_q;
        req_ready     = '0;
        write_ready   = '0;
        read_valid    = '0;
        read_data     = '0;
        m_req_valid   = 1'b0;
        m_req_rw      = 1'b0;
        m_req_burst   = 1'b0;
        m_req_addr    = '0;
        m_req_beats   = '0;
        m_write_valid = 1'b0;
        m_write_data  = '0;
        m_write_strb  = '0;
        m_read_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    grant_d = win;
                    state_d = StReq;
                end
            end
            StReq: begin
                m_req_valid = sel_req_valid;
                m_req_rw    = sel_rw;
                m_req_burst = sel_burst;
                m_req_addr  = sel_addr;
                m_req_beats = sel_eff_beats;
                req_ready   = grant_q & {N_REQ{m_req_ready}};
                if (sel_req_valid && m_req_ready) begin
                    beats_d = sel_eff_beats;
                    state_d = sel_rw ? StWrite : StRead;
                end
            end
            StWrite: begin
                m_write_valid = sel_write_valid;
                m_write_data  = sel_wdata;
                m_write_strb  = sel_wstrb;
                write_ready   = grant_q & {N_REQ{m_write_ready}};
                if (sel_write_valid && m_write_ready) begin
                    beats_d = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            StRead: begin
                read_valid   = grant_q & {N_REQ{m_read_valid}};
                read_data    = m_read_data;
                m_read_ready = sel_read_ready;
                if (m_read_valid && sel_read_ready) begin
                    beats_d = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= StIdle;
            grant_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_mam_req_arbiter.sv
// Self-checking bench for mam_req_arbiter: vector table plus scoreboarded corner sequences.
module tb_mam_req_arbiter;

    localparam int unsigned N   = 2;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 32;
    localparam int unsigned BW  = 14;
    localparam int unsigned SW  = DW / 8;
    localparam int          TMO = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_rw, req_burst, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*BW-1:0] req_beats;
    logic [N-1:0]    write_valid, write_ready;
    logic [N*DW-1:0] write_data;
    logic [N*SW-1:0] write_strb;
    logic [N-1:0]    read_valid, read_ready;
    logic [DW-1:0]   read_data;
    logic            m_req_valid, m_req_ready, m_req_rw, m_req_burst;
    logic [AW-1:0]   m_req_addr;
    logic [BW-1:0]   m_req_beats;
    logic            m_write_valid, m_write_ready;
    logic [DW-1:0]   m_write_data;
    logic [SW-1:0]   m_write_strb;
    logic            m_read_valid, m_read_ready;
    logic [DW-1:0]   m_read_data;

    mam_req_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLK_I         (clk),
        .RST_NI        (rst_n),
        .req_valid     (req_valid),
        .req_rw        (req_rw),
        .req_burst     (req_burst),
        .req_addr      (req_addr),
        .req_beats     (req_beats),
        .req_ready     (req_ready),
        .write_valid   (write_valid),
        .write_data    (write_data),
        .write_strb    (write_strb),
        .write_ready   (write_ready),
        .read_valid    (read_valid),
        .read_data     (read_data),
        .read_ready    (read_ready),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_req_rw      (m_req_rw),
        .m_req_burst   (m_req_burst),
        .m_req_addr    (m_req_addr),
        .m_req_beats   (m_req_beats),
        .m_write_valid (m_write_valid),
        .m_write_data  (m_write_data),
        .m_write_strb  (m_write_strb),
        .m_write_ready (m_write_ready),
        .m_read_valid  (m_read_valid),
        .m_read_data   (m_read_data),
        .m_read_ready  (m_read_ready)
    );

    typedef struct {
        int            idx;
        bit            rw;
        bit            burst;
        logic [AW-1:0] addr;
        logic [BW-1:0] beats;
    } req_exp_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } beat_exp_t;

    typedef struct {
        int            idx;
        bit            rw;
        bit            burst;
        logic [BW-1:0] beats;
        logic [AW-1:0] addr;
        int            n_beats;
        int            stall_beat;
        bit            toggle;
    } vec_t;

    req_exp_t  exp_req[$];
    beat_exp_t exp_w[$];
    beat_exp_t exp_r[$];
    req_exp_t  mon_req;
    beat_exp_t mon_beat;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [N-1:0] owner = '0;
    int         stall_cnt = 0;
    bit         toggle_en = 1'b0;
    int         toggle_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no handshake or an unexpected one, expected a scoreboarded event", name);
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic bit hs(input int kind);
        case (kind)
            0:       return m_req_valid && m_req_ready;
            1:       return m_write_valid && m_write_ready;
            default: return m_read_valid && m_read_ready;
        endcase
    endfunction

    // Scoreboard: every downstream handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            check("non_granted_quiet", 64'((req_ready | write_ready | read_valid) & ~owner), 64'd0);
            if (hs(0)) begin
                if (exp_req.size() == 0) begin
                    fail_event("req_unexpected");
                end else begin
                    mon_req = exp_req.pop_front();
                    check("req_grant", 64'(req_ready), 64'(oh(mon_req.idx)));
                    check("req_addr", 64'(m_req_addr), 64'(mon_req.addr));
                    check("req_rw", 64'(m_req_rw), 64'(mon_req.rw));
                    check("req_burst", 64'(m_req_burst), 64'(mon_req.burst));
                    check("req_beats", 64'(m_req_beats), 64'(mon_req.beats));
                end
            end
            if (hs(1)) begin
                if (exp_w.size() == 0) begin
                    fail_event("write_unexpected");
                end else begin
                    mon_beat = exp_w.pop_front();
                    check("write_grant", 64'(write_ready), 64'(oh(mon_beat.idx)));
                    check("write_data", 64'(m_write_data), 64'(mon_beat.data));
                    check("write_strb", 64'(m_write_strb), 64'(mon_beat.data[SW-1:0]));
                end
            end
            if (hs(2)) begin
                if (exp_r.size() == 0) begin
                    fail_event("read_unexpected");
                end else begin
                    mon_beat = exp_r.pop_front();
                    check("read_grant", 64'(read_valid), 64'(oh(mon_beat.idx)));
                    check("read_data", 64'(read_data), 64'(mon_beat.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_en) read_ready[toggle_idx] = ~read_ready[toggle_idx];
        if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) m_write_ready = 1'b1;
        end
    endtask

    task automatic wait_hs(input int kind, input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            if (hs(kind)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) fail_event(name);
    endtask

    task automatic set_req(input int idx, input bit rw, input bit burst, input logic [BW-1:0] beats,
                           input logic [AW-1:0] addr);
        req_rw[idx]               = rw;
        req_burst[idx]            = burst;
        req_addr[idx*AW +: AW]    = addr;
        req_beats[idx*BW +: BW]   = beats;
    endtask

    task automatic issue_req(input int idx, input bit rw, input bit burst, input logic [BW-1:0] beats,
                             input logic [AW-1:0] addr, input int n_beats);
        bit ok;
        set_req(idx, rw, burst, beats, addr);
        req_valid[idx] = 1'b1;
        owner          = oh(idx);
        exp_req.push_back('{idx, rw, burst, addr, BW'(n_beats)});
        wait_hs(0, "req_handshake", ok);
        step();
        req_valid[idx] = 1'b0;
    endtask

    task automatic data_phase(input int idx, input bit rw, input int n_beats, input int stall_beat);
        bit            ok;
        logic [DW-1:0] d;
        if (!rw) read_ready[idx] = 1'b1;
        for (int b = 0; b < n_beats; b++) begin
            d = DW'($urandom);
            if (rw) begin
                write_data[idx*DW +: DW] = d;
                write_strb[idx*SW +: SW] = d[SW-1:0];
                write_valid[idx]         = 1'b1;
                exp_w.push_back('{idx, d});
                if (b == stall_beat) begin
                    m_write_ready = 1'b0;
                    stall_cnt     = 2;
                end
            end else begin
                m_read_data  = d;
                m_read_valid = 1'b1;
                exp_r.push_back('{idx, d});
            end
            wait_hs(rw ? 1 : 2, rw ? "write_handshake" : "read_handshake", ok);
            if (!ok) break;
            step();
        end
        // Data still offered after the last beat: the port must already be back in IDLE.
        @(negedge clk);
        check("idle_after_last", 64'({m_write_valid, read_valid, m_req_valid}), 64'd0);
        step();
        write_valid[idx] = 1'b0;
        m_read_valid     = 1'b0;
        read_ready       = '0;
        toggle_en        = 1'b0;
        m_write_ready    = 1'b1;
        stall_cnt        = 0;
        owner            = '0;
    endtask

    function automatic logic [63:0] ctl_outs();
        return 64'({req_ready, write_ready, read_valid, m_req_valid, m_req_rw, m_req_burst,
                    m_write_valid, m_read_ready, m_req_beats, m_write_strb});
    endfunction

    function automatic logic [63:0] data_outs();
        return {read_data, m_req_addr, m_write_data};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t          vecs[5];
        int            cnt[N];
        int            last_w;
        int            w;
        bit            ok;
        logic [DW-1:0] d;

        vecs[0] = '{0, 1'b1, 1'b1, 14'd3, 32'h0000_1000, 3, 1, 1'b0};
        vecs[1] = '{0, 1'b0, 1'b1, 14'd0, 32'h0000_2000, 1, -1, 1'b0};
        vecs[2] = '{1, 1'b0, 1'b1, 14'd5, 32'h0000_3000, 5, -1, 1'b1};
        vecs[3] = '{1, 1'b1, 1'b0, 14'd7, 32'h0000_4000, 1, -1, 1'b0};
        vecs[4] = '{0, 1'b1, 1'b1, 14'd2, 32'h0000_5000, 2, 0, 1'b0};

        // Reset with busy-looking inputs: every output must still be 0.
        req_valid     = '1;
        req_rw        = '1;
        req_burst     = '1;
        req_addr      = '1;
        req_beats     = '1;
        write_valid   = '1;
        write_data    = '1;
        write_strb    = '1;
        read_ready    = '1;
        m_req_ready   = 1'b1;
        m_write_ready = 1'b1;
        m_read_valid  = 1'b1;
        m_read_data   = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl_outputs", ctl_outs(), 64'd0);
        check("reset_data_outputs", data_outs(), 64'd0);
        req_valid    = '0;
        write_valid  = '0;
        read_ready   = '0;
        m_read_valid = 1'b0;
        rst_n        = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            issue_req(vecs[v].idx, vecs[v].rw, vecs[v].burst, vecs[v].beats, vecs[v].addr,
                      vecs[v].n_beats);
            if (vecs[v].toggle) begin
                toggle_en  = 1'b1;
                toggle_idx = vecs[v].idx;
            end
            data_phase(vecs[v].idx, vecs[v].rw, vecs[v].n_beats, vecs[v].stall_beat);
        end

        // Contention: both requesters ask at once for four one-beat reads each.
        cnt    = '{default: 0};
        last_w = N - 1;
        set_req(0, 1'b0, 1'b0, 14'd0, 32'hC000_0000);
        set_req(1, 1'b0, 1'b0, 14'd0, 32'hC000_0001);
        req_valid  = '1;
        read_ready = '1;
        for (int t = 0; t < 8; t++) begin
`ifdef MAM_ARB_RR_EN
            w = req_valid[(last_w + 1) % 2] ? (last_w + 1) % 2 : last_w;
`else
            w = req_valid[0] ? 0 : 1;
`endif
            last_w = w;
            owner  = oh(w);
            exp_req.push_back('{w, 1'b0, 1'b0, 32'hC000_0000 + 32'(w), 14'd1});
            wait_hs(0, "contention_req", ok);
            if (!ok) break;
            cnt[w]++;
            step();
            if (cnt[w] == 4) req_valid[w] = 1'b0;
            d            = DW'($urandom);
            m_read_data  = d;
            m_read_valid = 1'b1;
            exp_r.push_back('{w, d});
            wait_hs(2, "contention_read", ok);
            if (!ok) break;
            step();
            m_read_valid = 1'b0;
        end
        check("contention_count0", 64'(cnt[0]), 64'd4);
        check("contention_count1", 64'(cnt[1]), 64'd4);
        req_valid  = '0;
        read_ready = '0;
        owner      = '0;
        step();

        // Back-to-back: req0 held high across two transactions.
        set_req(0, 1'b0, 1'b0, 14'd0, 32'hB2B0_0000);
        req_valid[0]  = 1'b1;
        read_ready[0] = 1'b1;
        owner         = oh(0);
        exp_req.push_back('{0, 1'b0, 1'b0, 32'hB2B0_0000, 14'd1});
        exp_req.push_back('{0, 1'b0, 1'b0, 32'hB2B0_0000, 14'd1});
        wait_hs(0, "b2b_req0", ok);
        step();
        d            = DW'($urandom);
        m_read_data  = d;
        m_read_valid = 1'b1;
        exp_r.push_back('{0, d});
        wait_hs(2, "b2b_read0", ok);
        step();
        m_read_valid = 1'b0;
        @(negedge clk);
        check("b2b_dead_cycle", 64'(m_req_valid), 64'd0);
        step();
        @(negedge clk);
        check("b2b_next_req", 64'(m_req_valid), 64'd1);
        step();
        req_valid[0] = 1'b0;
        data_phase(0, 1'b0, 1, -1);

        // Reset during beat 2 of a 4-beat write.
        issue_req(0, 1'b1, 1'b1, 14'd4, 32'h0000_7000, 4);
        d                    = DW'($urandom);
        write_data[0 +: DW]  = d;
        write_strb[0 +: SW]  = d[SW-1:0];
        write_valid[0]       = 1'b1;
        exp_w.push_back('{0, d});
        wait_hs(1, "rst_beat1", ok);
        step();
        write_data[0 +: DW] = 16'h5A5A;
        #1;
        check("rst_pre_write_active", 64'(m_write_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", ctl_outs(), 64'd0);
        check("rst_async_data", data_outs(), 64'd0);
        write_valid = '0;
        owner       = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_req(1, 1'b0, 1'b1, 14'd1, 32'h0000_8000);
        req_valid[1] = 1'b1;
        owner        = oh(1);
        exp_req.push_back('{1, 1'b0, 1'b1, 32'h0000_8000, 14'd1});
        @(negedge clk);
        check("rst_latency_same_cycle", 64'(m_req_valid), 64'd0);
        step();
        @(negedge clk);
        check("rst_latency_next_cycle", 64'(m_req_valid), 64'd1);
        step();
        req_valid[1] = 1'b0;
        data_phase(1, 1'b0, 1, -1);

        check("scoreboard_drained", 64'(exp_req.size() + exp_w.size() + exp_r.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mam_req_arbiter.md
# mam_req_arbiter

Shares a single MAM memory-access port (the req/write/read channel set consumed by `mam_wb_if`) between `N_REQ` requesters. It arbitrates on `req_valid` and locks the grant for one complete transaction: the request handshake plus every write or read data beat. While locked, it routes the granted requester's channels to the shared port. It sits between the MAM command decoders/DMA engines and the Wishbone bridge.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 16: data width in bits, multiple of 16.
- `ADDR_WIDTH`, 32: address width in bits.

Ports. Per-requester signals are flattened vectors; requester i occupies slice i.
- `CLK_I`  in  1  clock, all logic on rising edge.
- `RST_NI`  in  1  reset, asynchronous, active-low.
- `req_valid`, `req_rw`, `req_burst`  in  N_REQ each  per-requester request and attributes.
- `req_addr`  in  N_REQ*ADDR_WIDTH  request base addresses.
- `req_beats`  in  N_REQ*14  burst lengths.
- `req_ready`  out  N_REQ  request accepted.
- `write_valid`  in  N_REQ  per-requester write data valid.
- `write_data`  in  N_REQ*DATA_WIDTH  write data.
- `write_strb`  in  N_REQ*DATA_WIDTH/8  write byte strobes.
- `write_ready`  out  N_REQ  write beat accepted.
- `read_valid`  out  N_REQ  read data valid, granted requester only.
- `read_data`  out  DATA_WIDTH  read data, broadcast to all requesters.
- `read_ready`  in  N_REQ  read beat accepted.
- `m_req_*`, `m_write_*`, `m_read_*`  shared-port mirror of the single-requester channel set, with directions inverted. `m_read_data` is an input of width DATA_WIDTH.

## Operation
- FSM states: IDLE, REQ, WRITE, READ. `grant` is a one-hot register of width N_REQ. `beats_left` is a 14-bit counter.
- IDLE:
  - All outputs to requesters are 0. All `m_*` valid/ready outputs are 0.
  - If any `req_valid` is set, the selector picks a winner, registers `grant`, and the FSM moves to REQ.
- REQ:
  - `m_req_*` are driven from the granted slice.
  - `m_req_beats` = (`req_burst` && `req_beats`!=0) ? `req_beats` : 1. A zero-length burst is executed as one beat.
  - `req_ready[g]` = `m_req_ready`.
  - On handshake: load `beats_left` with the effective beat count, then go to WRITE if `req_rw`=1, otherwise READ.
- WRITE:
  - `m_write_valid/data/strb` come from slice g. `write_ready[g]` = `m_write_ready`.
  - Each `m_write_valid`&&`m_write_ready` decrements `beats_left`.
  - The handshake that occurs when `beats_left`==1 is the last beat: go to IDLE.
- READ:
  - `read_valid[g]` = `m_read_valid`. `m_read_ready` = `read_ready[g]`.
  - Counting is the same as WRITE. The last read handshake returns the FSM to IDLE.
- Non-granted requesters see `req_ready`, `write_ready` and `read_valid` held at 0. Their `read_ready`/`write_valid` are ignored.
- Grant is never revoked mid-transaction. A requester that deasserts `req_valid` in REQ before the handshake stalls the port; this is a protocol violation and is not recovered from.
- `RST_NI` low at any time: FSM goes to IDLE, `grant`=0, `beats_left`=0, last-winner pointer = N_REQ-1. The downstream bridge shares this reset.

## Timing
- Reset values: every output is 0.
- Arbitration latency: `req_valid` rises in cycle t, `m_req_valid` is asserted in t+1. There is no combinational path from `req_valid` to `m_req_valid`.
- REQ, WRITE and READ paths are combinational pass-through: zero added latency per beat.
- Back-to-back: the last-beat handshake in cycle t puts the FSM in IDLE at t+1. The next `m_req_valid` appears at t+2, giving one dead cycle between transactions.
- Simultaneous requests are resolved by the selector in the IDLE cycle. A requester that asserts `req_valid` during another requester's transaction waits for IDLE.

## Configuration
- `MAM_ARB_RR_EN` defined: round-robin. Search starts at (last winner + 1) mod N_REQ. The last-winner pointer updates on each grant.
- `MAM_ARB_RR_EN` undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package `mam_arb_pkg`:
  - state enum `mam_arb_state_t` (IDLE, REQ, WRITE, READ);
  - constant `MAM_BEATS_W`=14.
- Sub-module `mam_arb_select`: takes the request vector and last-winner pointer, and outputs the one-hot winner. It contains the `MAM_ARB_RR_EN` logic.

## Test plan
- Single write: req0 write, burst=1, beats=3; downstream ready stalls beat 2 for 2 cycles -> 3 write beats forwarded, then IDLE; req_ready[1]/write_ready[1] stay 0 throughout.
- Contention: req0 and req1 both assert in the same cycle, 4 transactions each -> RR build grants 0,1,0,1…; fixed-priority build grants 0 until req0 drops.
- Zero-length: burst=1, beats=0, read -> `m_req_beats`=1, exactly one read beat, then IDLE.
- Read backpressure: req1 read of 5 beats, `read_ready[1]` toggles every cycle -> 5 handshakes, `read_valid[0]` stays 0, `read_data` matches `m_read_data`.
- Reset mid-burst: `RST_NI` low during beat 2 of 4 -> all outputs 0 immediately; after release, a new request is granted with 1-cycle latency.
- Back-to-back: req0 asserted continuously, alone -> exactly one idle cycle between the last beat and the next `m_req_valid`.
